// File: rtl/mem_copy_engine.sv
// Byte-block copy engine acting as a bus initiator on the 8-bit memory bus.
// Each byte is one read issue, one read capture and one write cycle.
module mem_copy_engine (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] src_addr,
    input  logic [7:0] dst_addr,
    input  logic [7:0] length,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] count,
    output logic [7:0] mem_address,
    output logic [7:0] mem_wdata,
    output logic       mem_write,
    input  logic [7:0] mem_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RD_ISSUE   = 3'd1,
        ST_RD_CAPTURE = 3'd2,
        ST_WR         = 3'd3,
        ST_DONE       = 3'd4
    } state_t;

    state_t     state_r;
    logic [7:0] src_r;
    logic [7:0] dst_r;
    logic [7:0] remaining_r;
    logic [7:0] data_r;

    // 0xE0-0xEF has no device behind it
    function automatic logic is_unmapped(input logic [7:0] addr);
        return (addr[7:4] == 4'hE);
    endfunction

    function automatic logic is_writable(input logic [7:0] addr);
        return ((addr >= 8'h80) && (addr <= 8'hDF)) || (addr[7:4] == 4'hF);
    endfunction

    assign mem_wdata = data_r;

    // Transfer sequencer; every output is set on the edge entering the state it belongs to
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            src_r       <= 8'h00;
            dst_r       <= 8'h00;
            remaining_r <= 8'h00;
            data_r      <= 8'h00;
            mem_address <= 8'h00;
            mem_write   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            count       <= 8'h00;
        end else begin
            done      <= 1'b0;
            mem_write <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    mem_address <= 8'h00;
                    busy        <= 1'b0;
                    if (start) begin
                        src_r       <= src_addr;
                        dst_r       <= dst_addr;
                        remaining_r <= length;
                        count       <= 8'h00;
                        error       <= 1'b0;
                        if (length == 8'h00) begin
                            state_r <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r     <= ST_RD_ISSUE;
                            busy        <= 1'b1;
                            mem_address <= src_addr;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RD_ISSUE: begin
                    if (is_unmapped(src_r)) begin
                        error       <= 1'b1;
                        state_r     <= ST_DONE;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        mem_address <= 8'h00;
                    end else begin
                        state_r     <= ST_RD_CAPTURE;
                        mem_address <= src_r;
                    end
                end
                ST_RD_CAPTURE: begin
                    data_r      <= mem_rdata;
                    mem_address <= dst_r;
                    mem_write   <= is_writable(dst_r);
                    state_r     <= ST_WR;
                end
                ST_WR: begin
                    if (is_writable(dst_r)) begin
                        count       <= count + 8'd1;
                        src_r       <= src_r + 8'd1;
                        dst_r       <= dst_r + 8'd1;
                        remaining_r <= remaining_r - 8'd1;
                        if (remaining_r == 8'd1) begin
                            state_r     <= ST_DONE;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            mem_address <= 8'h00;
                        end else begin
                            state_r     <= ST_RD_ISSUE;
                            mem_address <= src_r + 8'd1;
                        end
                    end else begin
                        error       <= 1'b1;
                        state_r     <= ST_DONE;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        mem_address <= 8'h00;
                    end
                end
                ST_DONE: begin
                    state_r     <= ST_IDLE;
                    busy        <= 1'b0;
                    mem_address <= 8'h00;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    busy        <= 1'b0;
                    mem_address <= 8'h00;
                end
            endcase
        end
    end

endmodule
